layer0_input_quantizer: RTL and testbench

//  Front-end stage directly upstream of the layer0 LUT neurons. Accepts raw unsigned feature words
//  as a valid/ready stream, one feature per beat. Quantizes each feature to a 2-bit code with
//  per-feature thresholds and assembles NUM_FEAT codes into one vector. Presents the vector, double

---
 rtl/layer0_input_quantizer.sv | 151 +++++++++++++++
 tb/tb_layer0_input_quantizer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/layer0_input_quantizer.sv
// layer0_input_quantizer
// Front end of the layer0 LUT neurons. Takes raw unsigned features one per beat,
// turns each into a 2-bit threshold code and packs NUM_FEAT codes into one vector.
// The vector is presented on a double-buffered output: the assembly buffer keeps
// filling while the output register holds the previous vector.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// COLLECT   | accepting features into the assembly buffer (s_ready=1)
// STALL     | complete vector parked in assembly buffer, output full (s_ready=0)
// DISCARD   | long vector seen, dropping beats through the next s_last (s_ready=1)

module layer0_input_quantizer #(
    parameter int NUM_FEAT = 16,
    parameter int FEAT_W   = 8,
    parameter logic [NUM_FEAT*3*FEAT_W-1:0] THRESH =
        {NUM_FEAT{FEAT_W'(192), FEAT_W'(128), FEAT_W'(64)}}
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [FEAT_W-1:0]       s_data,
    input  logic                    s_last,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [2*NUM_FEAT-1:0]   m_data,
    output logic                    len_err,
    output logic [7:0]              err_count
);

    localparam int IDX_W = (NUM_FEAT > 1) ? $clog2(NUM_FEAT) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FEAT - 1);

    localparam logic [1:0] S_COLLECT = 2'd0;
    localparam logic [1:0] S_STALL   = 2'd1;
    localparam logic [1:0] S_DISCARD = 2'd2;

    logic [1:0]              state;
    logic [IDX_W-1:0]        idx;
    logic [2*NUM_FEAT-1:0]   asm_buf;
    logic [2*NUM_FEAT-1:0]   asm_next;
    logic [FEAT_W-1:0]       t0, t1, t2;
    logic [1:0]              code;

    logic accept;
    logic in_collect;
    logic is_final;
    logic beat_final_ok;
    logic beat_short;
    logic beat_long;
    logic out_free;
    logic load_new;
    logic stall_release;

    // s_ready is a pure function of state; only the STALL release depends on m_ready
    assign s_ready    = (state != S_STALL);
    assign accept     = s_valid && s_ready;
    assign in_collect = (state == S_COLLECT);
    assign is_final   = (idx == LAST_IDX);

    assign beat_final_ok = accept && in_collect && is_final && s_last;
    assign beat_short    = accept && in_collect && !is_final && s_last;
    assign beat_long     = accept && in_collect && is_final && !s_last;

    assign out_free      = !m_valid || m_ready;
    assign load_new      = beat_final_ok && out_free;
    assign stall_release = (state == S_STALL) && m_ready && m_valid;

    // Threshold lookup and quantization of the current beat, merged into slot idx
    always_comb begin
        t0 = THRESH[(3*int'(idx) + 0)*FEAT_W +: FEAT_W];
        t1 = THRESH[(3*int'(idx) + 1)*FEAT_W +: FEAT_W];
        t2 = THRESH[(3*int'(idx) + 2)*FEAT_W +: FEAT_W];
        code = {1'b0, (s_data >= t0)} + {1'b0, (s_data >= t1)} + {1'b0, (s_data >= t2)};
        asm_next = asm_buf;
        asm_next[2*int'(idx) +: 2] = code;
    end

    // Sequencing state and feature index
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_COLLECT;
            idx   <= '0;
        end else begin
            case (state)
                S_COLLECT: begin
                    if (beat_final_ok && !out_free)
                        state <= S_STALL;
                    else if (beat_long)
                        state <= S_DISCARD;
                end
                S_STALL: begin
                    if (stall_release)
                        state <= S_COLLECT;
                end
                S_DISCARD: begin
                    if (accept && s_last)
                        state <= S_COLLECT;
                end
                default: state <= S_COLLECT;
            endcase

            if (accept && in_collect) begin
                if (is_final || s_last)
                    idx <= '0;
                else
                    idx <= idx + 1'b1;
            end
        end
    end

    // Assembly buffer: written only by beats taken while collecting
    always_ff @(posedge clk) begin
        if (!rst_n)
            asm_buf <= '0;
        else if (accept && in_collect)
            asm_buf <= asm_next;
    end

    // Output register: direct load on a final beat, or transfer out of STALL
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            m_data  <= '0;
            m_valid <= 1'b0;
        end else begin
            if (load_new)
                m_data <= asm_next;
            else if (stall_release)
                m_data <= asm_buf;

            if (load_new || stall_release)
                m_valid <= 1'b1;
            else if (m_ready)
                m_valid <= 1'b0;
        end
    end

    // Length error pulse and saturating drop counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            len_err   <= 1'b0;
            err_count <= '0;
        end else begin
            len_err <= beat_short || beat_long;
            if ((beat_short || beat_long) && (err_count != 8'hFF))
                err_count <= err_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_layer0_input_quantizer.sv
// Directed bench for layer0_input_quantizer: a threshold table plus
// hand-written sequences for backpressure, length errors and streaming.

module tb_layer0_input_quantizer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        s_valid;
    logic        s_ready;
    logic [7:0]  s_data;
    logic        s_last;
    logic        m_valid;
    logic        m_ready;
    logic [31:0] m_data;
    logic        len_err;
    logic [7:0]  err_count;

    int total = 0;
    int bad   = 0;
    int sready_low = 0;

    logic [7:0] cur [0:63];

    typedef struct {
        logic [7:0] x;
        logic [1:0] code;
    } thr_vec_t;

    thr_vec_t tbl [16];

    layer0_input_quantizer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .s_last    (s_last),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .len_err   (len_err),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [1:0] qmodel(input logic [7:0] x);
        int c;
        c = (x >= 64 ? 1 : 0) + (x >= 128 ? 1 : 0) + (x >= 192 ? 1 : 0);
        return 2'(c);
    endfunction

    function automatic logic [31:0] expvec(input int base);
        logic [31:0] v;
        v = '0;
        for (int i = 0; i < 16; i++)
            v[2*i +: 2] = qmodel(cur[base + i]);
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [7:0] d, input logic l);
        int w;
        w = 0;
        if (!s_ready) sready_low++;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        while (!s_ready && w < 50) begin
            tick();
            w++;
        end
        if (!s_ready) chk("s_ready_timeout", {63'd0, s_ready}, 64'd1);
        tick();
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic send_vec(input int base);
        for (int i = 0; i < 16; i++)
            send_beat(cur[base + i], i == 15);
    endtask

    task automatic fill(input int seed);
        for (int i = 0; i < 64; i++)
            cur[i] = 8'((i * 37 + seed * 11 + 5) & 255);
    endtask

    initial begin
        int pulses;
        int mv_seen;
        logic [7:0] xs [0:7];

        xs[0] = 8'd0;   xs[1] = 8'd63;  xs[2] = 8'd64;  xs[3] = 8'd127;
        xs[4] = 8'd128; xs[5] = 8'd191; xs[6] = 8'd192; xs[7] = 8'd255;
        for (int i = 0; i < 16; i++) begin
            tbl[i].x = xs[i % 8];
            case (i % 8)
                0, 1: tbl[i].code = 2'd0;
                2, 3: tbl[i].code = 2'd1;
                4, 5: tbl[i].code = 2'd2;
                default: tbl[i].code = 2'd3;
            endcase
        end

        // reset with random inputs
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            s_valid = 1'($urandom_range(0, 1));
            s_data  = 8'($urandom_range(0, 255));
            s_last  = 1'($urandom_range(0, 1));
            m_ready = 1'($urandom_range(0, 1));
            tick();
        end
        s_valid = 1'b0; s_data = 8'd0; s_last = 1'b0; m_ready = 1'b1;
        rst_n = 1'b1;
        chk("rst_m_valid",   {63'd0, m_valid}, 64'd0);
        chk("rst_m_data",    {32'd0, m_data}, 64'd0);
        chk("rst_err_count", {56'd0, err_count}, 64'd0);
        chk("rst_len_err",   {63'd0, len_err}, 64'd0);
        tick();
        chk("rst_s_ready",   {63'd0, s_ready}, 64'd1);

        // threshold table
        for (int i = 0; i < 16; i++) begin
            if (i == 15) chk("thr_m_valid_before", {63'd0, m_valid}, 64'd0);
            send_beat(tbl[i].x, i == 15);
        end
        chk("thr_m_valid_latency", {63'd0, m_valid}, 64'd1);
        for (int i = 0; i < 16; i++)
            chk($sformatf("thr_code_%0d", i), {62'd0, m_data[2*i +: 2]}, {62'd0, tbl[i].code});
        tick();
        chk("thr_m_valid_drop", {63'd0, m_valid}, 64'd0);

        // backpressure: A held, B stalls, then released with no bubble
        fill(1);
        m_ready = 1'b0;
        send_vec(0);
        chk("bp_a_valid", {63'd0, m_valid}, 64'd1);
        chk("bp_a_data",  {32'd0, m_data}, {32'd0, expvec(0)});
        for (int i = 0; i < 15; i++) send_beat(cur[16 + i], 1'b0);
        chk("bp_a_stable", {32'd0, m_data}, {32'd0, expvec(0)});
        chk("bp_s_ready_pre", {63'd0, s_ready}, 64'd1);
        send_beat(cur[31], 1'b1);
        chk("bp_s_ready_stall", {63'd0, s_ready}, 64'd0);
        tick();
        chk("bp_a_held", {32'd0, m_data}, {32'd0, expvec(0)});
        chk("bp_s_ready_still", {63'd0, s_ready}, 64'd0);
        m_ready = 1'b1;
        tick();
        chk("bp_b_data",    {32'd0, m_data}, {32'd0, expvec(16)});
        chk("bp_b_valid",   {63'd0, m_valid}, 64'd1);
        chk("bp_s_ready_back", {63'd0, s_ready}, 64'd1);
        tick();
        chk("bp_drained", {63'd0, m_valid}, 64'd0);

        // short vector
        fill(2);
        for (int i = 0; i < 5; i++) send_beat(cur[i], i == 4);
        chk("short_len_err", {63'd0, len_err}, 64'd1);
        tick();
        chk("short_len_err_pulse", {63'd0, len_err}, 64'd0);
        chk("short_err_count", {56'd0, err_count}, 64'd1);
        chk("short_no_valid", {63'd0, m_valid}, 64'd0);
        send_vec(16);
        chk("short_next_valid", {63'd0, m_valid}, 64'd1);
        chk("short_next_data",  {32'd0, m_data}, {32'd0, expvec(16)});
        tick();

        // long vector: 20 beats, s_last on 20th
        fill(3);
        pulses = 0; mv_seen = 0;
        for (int i = 0; i < 20; i++) begin
            send_beat(cur[i], i == 19);
            if (len_err) pulses++;
            if (m_valid) mv_seen++;
        end
        tick();
        if (len_err) pulses++;
        chk("long_pulses", 64'(pulses), 64'd1);
        chk("long_no_output", 64'(mv_seen), 64'd0);
        chk("long_err_count", {56'd0, err_count}, 64'd2);
        send_vec(32);
        chk("long_next_valid", {63'd0, m_valid}, 64'd1);
        chk("long_next_data",  {32'd0, m_data}, {32'd0, expvec(32)});
        chk("long_next_no_err", {56'd0, err_count}, 64'd2);
        tick();

        // saturation with 300 single-beat short vectors
        for (int i = 0; i < 300; i++) begin
            send_beat(8'(i), 1'b1);
            if (i == 99) chk("sat_mid_count", {56'd0, err_count}, 64'd102);
        end
        tick();
        chk("sat_err_count", {56'd0, err_count}, 64'd255);

        // streaming: 4 back-to-back vectors, m_ready=1
        fill(4);
        sready_low = 0; mv_seen = 0;
        for (int v = 0; v < 4; v++) begin
            for (int i = 0; i < 16; i++) begin
                send_beat(cur[16*v + i], i == 15);
                if (m_valid) begin
                    mv_seen++;
                    chk($sformatf("stream_data_%0d", v), {32'd0, m_data}, {32'd0, expvec(16*v)});
                end
            end
        end
        tick();
        if (m_valid) mv_seen++;
        chk("stream_valid_beats", 64'(mv_seen), 64'd4);
        chk("stream_s_ready_low", 64'(sready_low), 64'd0);
        chk("stream_sat_hold", {56'd0, err_count}, 64'd255);

        // reset mid-vector discards the partial vector
        fill(5);
        for (int i = 0; i < 7; i++) send_beat(cur[i], 1'b0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("midrst_err_count", {56'd0, err_count}, 64'd0);
        send_vec(16);
        chk("midrst_valid", {63'd0, m_valid}, 64'd1);
        chk("midrst_data",  {32'd0, m_data}, {32'd0, expvec(16)});
        chk("midrst_no_err", {56'd0, err_count}, 64'd0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
